// File: rtl/victim_buffer_pkg.sv
// Shared types for the victim buffer: tag, line and word widths plus the
// controller state encoding.
package victim_buffer_pkg;

    typedef logic [11:0]  victim_tag;
    typedef logic [127:0] lc3b_line;
    typedef logic [15:0]  lc3b_word;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        WRITEBACK,
        INSERT
    } vc_state_t;

endpackage

// File: rtl/victim_buffer_if.sv
// Victim buffer bus: L1 lookup/evict handshakes and the pmem writeback port.
// The slave modport is the victim buffer; master is the L1 + memory side.
interface victim_buffer_if;
    import victim_buffer_pkg::*;

    logic      lookup_req;
    victim_tag lookup_tag;
    logic      lookup_done;
    logic      lookup_hit;
    lc3b_line  lookup_rdata;
    logic      lookup_dirty;

    logic      evict_req;
    victim_tag evict_tag;
    lc3b_line  evict_wdata;
    logic      evict_dirty;
    logic      evict_done;

    logic      pmem_write;
    lc3b_word  pmem_address;
    lc3b_line  pmem_wdata;
    logic      pmem_resp;

    modport slave (
        input  lookup_req, lookup_tag, evict_req, evict_tag, evict_wdata,
               evict_dirty, pmem_resp,
        output lookup_done, lookup_hit, lookup_rdata, lookup_dirty,
               evict_done, pmem_write, pmem_address, pmem_wdata
    );

    modport master (
        output lookup_req, lookup_tag, evict_req, evict_tag, evict_wdata,
               evict_dirty, pmem_resp,
        input  lookup_done, lookup_hit, lookup_rdata, lookup_dirty,
               evict_done, pmem_write, pmem_address, pmem_wdata
    );

endinterface

// File: rtl/victim_lru.sv
// Replacement state for the victim buffer.
// VICTIM_LRU_EN defined: true LRU with a per-entry age (ENTRIES-1 = oldest).
// VICTIM_LRU_EN undefined: FIFO round-robin pointer that only advances when
// an insert displaced a valid line.
module victim_lru #(
    parameter int ENTRIES = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ins_stb,
    input  logic [$clog2(ENTRIES)-1:0] ins_idx,
    input  logic                       ins_replace,
    input  logic                       inv_stb,
    input  logic [$clog2(ENTRIES)-1:0] inv_idx,
    output logic [$clog2(ENTRIES)-1:0] victim_idx
);
    localparam int IW = $clog2(ENTRIES);

`ifdef VICTIM_LRU_EN
    logic [IW-1:0] age [ENTRIES];
    logic          unused_inputs;

    assign unused_inputs = ins_replace;

    // Insert makes an entry youngest; invalidate makes it oldest
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) age[i] <= IW'(i);
        end else if (ins_stb) begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (IW'(i) == ins_idx)          age[i] <= '0;
                else if (age[i] < age[ins_idx]) age[i] <= age[i] + 1'b1;
            end
        end else if (inv_stb) begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (IW'(i) == inv_idx)          age[i] <= IW'(ENTRIES - 1);
                else if (age[i] > age[inv_idx]) age[i] <= age[i] - 1'b1;
            end
        end
    end

    // Victim is whichever entry currently holds the oldest age
    always_comb begin
        victim_idx = '0;
        for (int i = 0; i < ENTRIES; i++)
            if (age[i] == IW'(ENTRIES - 1)) victim_idx = IW'(i);
    end
`else
    logic [IW-1:0] ptr;
    logic          unused_inputs;

    assign unused_inputs = ^{inv_stb, inv_idx, ins_idx};
    assign victim_idx    = ptr;

    // Pointer wraps naturally since ENTRIES is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      ptr <= '0;
        else if (ins_stb && ins_replace) ptr <= ptr + 1'b1;
    end
`endif

endmodule

// File: rtl/victim_buffer.sv
// Four-entry (by default) fully-associative victim buffer between L1 and pmem.
// Lookups swap a hit line out to L1; evicts install lines, writing back a
// displaced dirty line first. Replacement policy selected by VICTIM_LRU_EN.
module victim_buffer
    import victim_buffer_pkg::*;
#(
    parameter int ENTRIES = 4
) (
    input logic              clk,
    input logic              rst_n,
    victim_buffer_if.slave   bus
);
    localparam int IW = $clog2(ENTRIES);

    vc_state_t            state;
    logic [ENTRIES-1:0]   valid;
    logic [ENTRIES-1:0]   dirty;
    victim_tag            tags  [ENTRIES];
    lc3b_line             lines [ENTRIES];

    logic [IW-1:0]        slot;
    logic                 ev_dirty;
    logic                 ev_replace;
    victim_tag            ev_tag;
    lc3b_line             ev_line;

    logic                 lk_hit;
    logic [IW-1:0]        lk_idx;
    logic                 ev_match;
    logic [IW-1:0]        ev_match_idx;
    logic                 ev_free;
    logic [IW-1:0]        ev_free_idx;
    logic [IW-1:0]        victim_idx;
    logic [IW-1:0]        slot_sel;
    logic                 replace;
    logic                 need_wb;

    // Tag match for lookups and slot choice for evicts, both from live inputs
    always_comb begin
        lk_hit       = 1'b0;
        lk_idx       = '0;
        ev_match     = 1'b0;
        ev_match_idx = '0;
        ev_free      = 1'b0;
        ev_free_idx  = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (!lk_hit && valid[i] && tags[i] == bus.lookup_tag) begin
                lk_hit = 1'b1;
                lk_idx = IW'(i);
            end
            if (!ev_match && valid[i] && tags[i] == bus.evict_tag) begin
                ev_match     = 1'b1;
                ev_match_idx = IW'(i);
            end
            if (!ev_free && !valid[i]) begin
                ev_free     = 1'b1;
                ev_free_idx = IW'(i);
            end
        end
        replace  = !ev_match && !ev_free;
        slot_sel = ev_match ? ev_match_idx : (ev_free ? ev_free_idx : victim_idx);
        need_wb  = valid[slot_sel] && dirty[slot_sel] && (tags[slot_sel] != bus.evict_tag);
    end

    // Controller; outputs are registered on the edge that enters each state so
    // the done pulse lands in the LOOKUP/INSERT cycle itself
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            valid            <= '0;
            dirty            <= '0;
            slot             <= '0;
            ev_dirty         <= 1'b0;
            ev_replace       <= 1'b0;
            bus.lookup_done  <= 1'b0;
            bus.lookup_hit   <= 1'b0;
            bus.lookup_rdata <= '0;
            bus.lookup_dirty <= 1'b0;
            bus.evict_done   <= 1'b0;
            bus.pmem_write   <= 1'b0;
            bus.pmem_address <= '0;
            bus.pmem_wdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.lookup_req) begin
                        state            <= LOOKUP;
                        bus.lookup_done  <= 1'b1;
                        bus.lookup_hit   <= lk_hit;
                        bus.lookup_rdata <= lk_hit ? lines[lk_idx] : '0;
                        bus.lookup_dirty <= lk_hit && dirty[lk_idx];
                        if (lk_hit) begin
                            valid[lk_idx] <= 1'b0;
                            dirty[lk_idx] <= 1'b0;
                        end
                    end else if (bus.evict_req) begin
                        slot       <= slot_sel;
                        ev_dirty   <= bus.evict_dirty;
                        ev_replace <= replace;
                        if (need_wb) begin
                            state            <= WRITEBACK;
                            bus.pmem_write   <= 1'b1;
                            bus.pmem_address <= {tags[slot_sel], 4'b0000};
                            bus.pmem_wdata   <= lines[slot_sel];
                        end else begin
                            state          <= INSERT;
                            bus.evict_done <= 1'b1;
                        end
                    end
                end
                LOOKUP: begin
                    state            <= IDLE;
                    bus.lookup_done  <= 1'b0;
                    bus.lookup_hit   <= 1'b0;
                    bus.lookup_rdata <= '0;
                    bus.lookup_dirty <= 1'b0;
                end
                WRITEBACK: begin
                    if (bus.pmem_resp) begin
                        state            <= INSERT;
                        bus.pmem_write   <= 1'b0;
                        bus.pmem_address <= '0;
                        bus.pmem_wdata   <= '0;
                        bus.evict_done   <= 1'b1;
                    end
                end
                INSERT: begin
                    state          <= IDLE;
                    valid[slot]    <= 1'b1;
                    dirty[slot]    <= ev_dirty;
                    bus.evict_done <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Evict payload capture; pure data, so no reset
    always_ff @(posedge clk) begin
        if (state == IDLE && !bus.lookup_req && bus.evict_req) begin
            ev_tag  <= bus.evict_tag;
            ev_line <= bus.evict_wdata;
        end
    end

    // Line storage write on install; pure data, so no reset
    always_ff @(posedge clk) begin
        if (state == INSERT) begin
            tags[slot]  <= ev_tag;
            lines[slot] <= ev_line;
        end
    end

    victim_lru #(.ENTRIES(ENTRIES)) u_lru (
        .clk         (clk),
        .rst_n       (rst_n),
        .ins_stb     (state == INSERT),
        .ins_idx     (slot),
        .ins_replace (ev_replace),
        .inv_stb     (state == IDLE && bus.lookup_req && lk_hit),
        .inv_idx     (lk_idx),
        .victim_idx  (victim_idx)
    );

endmodule

// File: tb/tb_victim_buffer.sv
// Directed testbench for victim_buffer; honours VICTIM_LRU_EN for the
// replacement-order scenario.
module tb_victim_buffer;
    import victim_buffer_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   pmem_cnt = 0;

    victim_buffer_if vif();

    victim_buffer #(.ENTRIES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (vif)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (vif.pmem_write === 1'b1) pmem_cnt++;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog");
    end

    function automatic lc3b_line line_of(input victim_tag t, input logic [3:0] salt);
        return {8{salt, t}};
    endfunction

    task automatic do_reset;
        vif.lookup_req  = 1'b0;
        vif.lookup_tag  = '0;
        vif.evict_req   = 1'b0;
        vif.evict_tag   = '0;
        vif.evict_wdata = '0;
        vif.evict_dirty = 1'b0;
        vif.pmem_resp   = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic do_lookup(input victim_tag t, output logic done, output logic hit,
                             output lc3b_line rdata, output logic dty);
        @(negedge clk);
        vif.lookup_req = 1'b1;
        vif.lookup_tag = t;
        @(posedge clk); #1;
        done  = vif.lookup_done;
        hit   = vif.lookup_hit;
        rdata = vif.lookup_rdata;
        dty   = vif.lookup_dirty;
        @(negedge clk);
        vif.lookup_req = 1'b0;
        @(posedge clk); #1;
    endtask

    // cycles = edges from request to evict_done (0 on timeout)
    task automatic do_evict(input victim_tag t, input lc3b_line d, input logic dty,
                            input int resp_delay, output int cycles, output int wb,
                            output lc3b_word wb_addr, output lc3b_line wb_data);
        cycles = 0; wb = 0; wb_addr = '0; wb_data = '0;
        @(negedge clk);
        vif.evict_req   = 1'b1;
        vif.evict_tag   = t;
        vif.evict_wdata = d;
        vif.evict_dirty = dty;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (vif.evict_done === 1'b1) begin
                cycles = c;
                break;
            end
            if (vif.pmem_write === 1'b1) begin
                wb++;
                wb_addr = vif.pmem_address;
                wb_data = vif.pmem_wdata;
                vif.pmem_resp = (wb >= resp_delay);
            end
        end
        vif.pmem_resp = 1'b0;
        @(negedge clk);
        vif.evict_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        do_reset();
        #1;
        total++;
        if ({vif.lookup_done, vif.lookup_hit, vif.lookup_dirty, vif.evict_done, vif.pmem_write} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b required 00000",
                     {vif.lookup_done, vif.lookup_hit, vif.lookup_dirty, vif.evict_done, vif.pmem_write});
        end
        total++;
        if (vif.lookup_rdata !== '0) begin
            bad++; $display("FAIL reset_rdata: got %h required 0", vif.lookup_rdata);
        end
        total++;
        if (vif.pmem_address !== 16'h0000 || vif.pmem_wdata !== '0) begin
            bad++; $display("FAIL reset_pmem: got %h/%h required 0/0", vif.pmem_address, vif.pmem_wdata);
        end
    endtask

    task automatic test_lookup_miss;
        logic done, hit, dty; lc3b_line rd; int p0;
        do_reset();
        p0 = pmem_cnt;
        do_lookup(12'h0A1, done, hit, rd, dty);
        total++;
        if (done !== 1'b1 || hit !== 1'b0 || dty !== 1'b0) begin
            bad++; $display("FAIL miss_flags: done=%b hit=%b dirty=%b required 1 0 0", done, hit, dty);
        end
        total++;
        if (rd !== '0) begin
            bad++; $display("FAIL miss_rdata: got %h required 0", rd);
        end
        total++;
        if (vif.lookup_done !== 1'b0) begin
            bad++; $display("FAIL miss_done_pulse: got %b required 0", vif.lookup_done);
        end
        // stray pmem_resp in IDLE must do nothing
        @(negedge clk); vif.pmem_resp = 1'b1;
        @(negedge clk); vif.pmem_resp = 1'b0;
        @(posedge clk); #1;
        total++;
        if (pmem_cnt !== p0 || vif.evict_done !== 1'b0) begin
            bad++; $display("FAIL miss_no_pmem: pmem cycles=%0d evict_done=%b required %0d 0", pmem_cnt, vif.evict_done, p0);
        end
    endtask

    task automatic test_evict_hit;
        logic done, hit, dty; lc3b_line rd; int cyc, wb; lc3b_word wa; lc3b_line wd;
        do_reset();
        do_evict(12'h123, line_of(12'h123, 4'h5), 1'b0, 1, cyc, wb, wa, wd);
        total++;
        if (cyc !== 1 || wb !== 0) begin
            bad++; $display("FAIL evict_latency: cycles=%0d wb=%0d required 1 0", cyc, wb);
        end
        do_lookup(12'h123, done, hit, rd, dty);
        total++;
        if (done !== 1'b1 || hit !== 1'b1 || dty !== 1'b0 || rd !== line_of(12'h123, 4'h5)) begin
            bad++; $display("FAIL evict_hit: done=%b hit=%b dirty=%b rdata=%h required 1 1 0 %h",
                            done, hit, dty, rd, line_of(12'h123, 4'h5));
        end
        do_lookup(12'h123, done, hit, rd, dty);
        total++;
        if (done !== 1'b1 || hit !== 1'b0 || rd !== '0) begin
            bad++; $display("FAIL swap_out_invalidates: done=%b hit=%b rdata=%h required 1 0 0", done, hit, rd);
        end
    endtask

    task automatic test_writeback;
        logic done, hit, dty; lc3b_line rd; int cyc, wb; lc3b_word wa; lc3b_line wd;
        do_reset();
        for (int t = 1; t <= 4; t++) begin
            do_evict(12'(t), line_of(12'(t), 4'hC), 1'b1, 1, cyc, wb, wa, wd);
            total++;
            if (cyc !== 1 || wb !== 0) begin
                bad++; $display("FAIL fill_dirty_%0d: cycles=%0d wb=%0d required 1 0", t, cyc, wb);
            end
        end
        do_evict(12'h005, line_of(12'h005, 4'hC), 1'b0, 3, cyc, wb, wa, wd);
        total++;
        if (wb !== 3 || cyc !== 4) begin
            bad++; $display("FAIL wb_timing: pmem_write cycles=%0d done at %0d required 3 4", wb, cyc);
        end
        total++;
        if (wa !== 16'h0010 || wd !== line_of(12'h001, 4'hC)) begin
            bad++; $display("FAIL wb_payload: addr=%h data=%h required 0010 %h", wa, wd, line_of(12'h001, 4'hC));
        end
        do_lookup(12'h001, done, hit, rd, dty);
        total++;
        if (hit !== 1'b0) begin
            bad++; $display("FAIL wb_displaced: hit=%b required 0", hit);
        end
        do_lookup(12'h005, done, hit, rd, dty);
        total++;
        if (hit !== 1'b1 || dty !== 1'b0 || rd !== line_of(12'h005, 4'hC)) begin
            bad++; $display("FAIL wb_new_line: hit=%b dirty=%b rdata=%h required 1 0 %h", hit, dty, rd, line_of(12'h005, 4'hC));
        end
        do_lookup(12'h002, done, hit, rd, dty);
        total++;
        if (hit !== 1'b1 || dty !== 1'b1) begin
            bad++; $display("FAIL dirty_hit: hit=%b dirty=%b required 1 1", hit, dty);
        end
    endtask

    task automatic test_same_tag;
        logic done, hit, dty; lc3b_line rd; int cyc, wb; lc3b_word wa; lc3b_line wd;
        do_reset();
        do_evict(12'h009, line_of(12'h009, 4'h1), 1'b1, 1, cyc, wb, wa, wd);
        do_evict(12'h009, line_of(12'h009, 4'h2), 1'b1, 1, cyc, wb, wa, wd);
        total++;
        if (cyc !== 1 || wb !== 0) begin
            bad++; $display("FAIL same_tag_no_wb: cycles=%0d wb=%0d required 1 0", cyc, wb);
        end
        do_lookup(12'h009, done, hit, rd, dty);
        total++;
        if (hit !== 1'b1 || dty !== 1'b1 || rd !== line_of(12'h009, 4'h2)) begin
            bad++; $display("FAIL same_tag_data: hit=%b dirty=%b rdata=%h required 1 1 %h", hit, dty, rd, line_of(12'h009, 4'h2));
        end
    endtask

    task automatic test_replacement;
        logic done, hit, dty; lc3b_line rd; int cyc, wb; lc3b_word wa; lc3b_line wd;
        logic exp5, exp3;
`ifdef VICTIM_LRU_EN
        exp5 = 1'b1; exp3 = 1'b0;
`else
        exp5 = 1'b0; exp3 = 1'b1;
`endif
        do_reset();
        for (int t = 1; t <= 4; t++)
            do_evict(12'(t), line_of(12'(t), 4'h7), 1'b0, 1, cyc, wb, wa, wd);
        do_lookup(12'h002, done, hit, rd, dty);
        total++;
        if (hit !== 1'b1) begin
            bad++; $display("FAIL repl_lookup2: hit=%b required 1", hit);
        end
        for (int t = 5; t <= 7; t++) begin
            do_evict(12'(t), line_of(12'(t), 4'h7), 1'b0, 1, cyc, wb, wa, wd);
            total++;
            if (cyc !== 1 || wb !== 0) begin
                bad++; $display("FAIL repl_evict_%0d: cycles=%0d wb=%0d required 1 0", t, cyc, wb);
            end
        end
        do_lookup(12'h005, done, hit, rd, dty);
        total++;
        if (hit !== exp5) begin
            bad++; $display("FAIL repl_tag5: hit=%b required %b", hit, exp5);
        end
        do_lookup(12'h003, done, hit, rd, dty);
        total++;
        if (hit !== exp3) begin
            bad++; $display("FAIL repl_tag3: hit=%b required %b", hit, exp3);
        end
        do_lookup(12'h001, done, hit, rd, dty);
        total++;
        if (hit !== 1'b0) begin
            bad++; $display("FAIL repl_tag1: hit=%b required 0", hit);
        end
    endtask

    task automatic test_back_to_back;
        logic done, hit, dty, lk_hit; lc3b_line rd; int lk_cyc, ev_cyc;
        do_reset();
        lk_cyc = 0; ev_cyc = 0; lk_hit = 1'bx;
        @(negedge clk);
        vif.lookup_req  = 1'b1;
        vif.lookup_tag  = 12'h077;
        vif.evict_req   = 1'b1;
        vif.evict_tag   = 12'h077;
        vif.evict_wdata = line_of(12'h077, 4'h3);
        vif.evict_dirty = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (vif.lookup_done === 1'b1 && lk_cyc == 0) begin
                lk_cyc = c; lk_hit = vif.lookup_hit; vif.lookup_req = 1'b0;
            end
            if (vif.evict_done === 1'b1 && ev_cyc == 0) begin
                ev_cyc = c; vif.evict_req = 1'b0;
            end
        end
        vif.lookup_req = 1'b0;
        vif.evict_req  = 1'b0;
        total++;
        if (lk_cyc !== 1 || lk_hit !== 1'b0) begin
            bad++; $display("FAIL b2b_lookup_first: done at %0d hit=%b required 1 0", lk_cyc, lk_hit);
        end
        total++;
        if (!(ev_cyc > lk_cyc && ev_cyc <= lk_cyc + 2)) begin
            bad++; $display("FAIL b2b_evict_after: evict_done at %0d lookup_done at %0d required after lookup", ev_cyc, lk_cyc);
        end
        do_lookup(12'h077, done, hit, rd, dty);
        total++;
        if (hit !== 1'b1 || rd !== line_of(12'h077, 4'h3)) begin
            bad++; $display("FAIL b2b_installed: hit=%b rdata=%h required 1 %h", hit, rd, line_of(12'h077, 4'h3));
        end
    endtask

    task automatic test_reset_in_writeback;
        logic done, hit, dty; lc3b_line rd; int cyc, wb; lc3b_word wa; lc3b_line wd;
        do_reset();
        for (int t = 1; t <= 4; t++)
            do_evict(12'(t), line_of(12'(t), 4'h9), 1'b1, 1, cyc, wb, wa, wd);
        @(negedge clk);
        vif.evict_req   = 1'b1;
        vif.evict_tag   = 12'h005;
        vif.evict_wdata = line_of(12'h005, 4'h9);
        vif.evict_dirty = 1'b0;
        @(posedge clk); #1;
        total++;
        if (vif.pmem_write !== 1'b1) begin
            bad++; $display("FAIL rst_wb_entered: pmem_write=%b required 1", vif.pmem_write);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (vif.pmem_write !== 1'b0 || vif.evict_done !== 1'b0) begin
            bad++; $display("FAIL rst_wb_drop: pmem_write=%b evict_done=%b required 0 0", vif.pmem_write, vif.evict_done);
        end
        vif.evict_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int t = 1; t <= 5; t++) begin
            do_lookup(12'(t), done, hit, rd, dty);
            total++;
            if (done !== 1'b1 || hit !== 1'b0) begin
                bad++; $display("FAIL rst_wb_lookup_%0d: done=%b hit=%b required 1 0", t, done, hit);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lookup_miss();
        test_evict_hit();
        test_writeback();
        test_same_tag();
        test_replacement();
        test_back_to_back();
        test_reset_in_writeback();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
